// File: rtl/key_debounce_array.sv
// key_debounce_array: N independent key channels, each with a synchroniser, debounce window, press/release pulses and long-press detection
module key_debounce_array #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int LONG_CYCLES     = 1000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic              clk_1KHz,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic          r_s1, r_s2, r_state, r_press, r_release, r_long;
        logic [DW-1:0] r_dcnt;
        logic [LW-1:0] r_lcnt;
        logic          w_p, w_expire, w_fall, w_lsat;

        assign w_p      = keys_in[g] ^ ACTIVE_LOW;
        assign w_expire = (r_s2 != r_state) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
        assign w_fall   = w_expire && r_state;
        assign w_lsat   = r_lcnt == LW'(LONG_CYCLES);

        // Synchronise, filter and time one key; pulses are registered alongside the level they report.
        // Synchronisers reset to the released level so a key held through reset is seen as a fresh press.
        always_ff @(posedge clk_1KHz) begin
            if (!rst_n) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_state   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_dcnt    <= '0;
                r_lcnt    <= '0;
            end else begin
                r_s1      <= w_p;
                r_s2      <= r_s1;
                r_dcnt    <= (r_s2 == r_state || w_expire) ? '0 : r_dcnt + 1'b1;
                r_state   <= w_expire ? r_s2 : r_state;
                r_press   <= w_expire && r_s2;
                r_release <= w_fall;
                r_lcnt    <= (!r_state || w_fall) ? '0 : w_lsat ? r_lcnt : r_lcnt + 1'b1;
                r_long    <= r_state && !w_fall && (r_lcnt == LW'(LONG_CYCLES - 1));
            end
        end

        assign key_state[g]   = r_state;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
        assign key_long[g]    = r_long;
    end
endmodule

// File: tb/tb_key_debounce_array.sv
// tb_key_debounce_array: directed checks of debounce, pulses, long press, reset and active-low inputs
module tb_key_debounce_array;
    logic       clk_1KHz;
    logic       rst_n;
    logic [3:0] keys_a, keys_b;
    logic [3:0] state_a, press_a, release_a, long_a;
    logic [3:0] state_b, press_b, release_b, long_b;
    int         errors = 0;
    int         checks = 0;
    int         press_cnt [4];
    int         rel_cnt   [4];
    int         long_cnt  [4];
    int         p0, r0, l0;

    key_debounce_array #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b0)) dut (
        .clk_1KHz(clk_1KHz), .rst_n(rst_n), .keys_in(keys_a),
        .key_state(state_a), .key_press(press_a), .key_release(release_a), .key_long(long_a)
    );

    key_debounce_array #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b1)) dut_al (
        .clk_1KHz(clk_1KHz), .rst_n(rst_n), .keys_in(keys_b),
        .key_state(state_b), .key_press(press_b), .key_release(release_b), .key_long(long_b)
    );

    initial begin
        clk_1KHz = 1'b0;
        forever #5 clk_1KHz = ~clk_1KHz;
    end

    // Tally every pulse seen on the main instance, sampled mid-cycle
    initial begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
    end
    always @(negedge clk_1KHz) begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] <= press_cnt[i] + int'(press_a[i]);
            rel_cnt[i]   <= rel_cnt[i] + int'(release_a[i]);
            long_cnt[i]  <= long_cnt[i] + int'(long_a[i]);
        end
    end

    task automatic tick();
        @(posedge clk_1KHz);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        keys_a = 4'h0;
        keys_b = 4'hF;
        ticks(3);
        chk("reset_state_a", {28'd0, state_a}, 32'd0);
        chk("reset_pulses_a", {20'd0, press_a, release_a, long_a}, 32'd0);
        chk("reset_state_b", {28'd0, state_b}, 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // clean press on channel 0
        keys_a[0] = 1'b1;
        ticks(5);
        chk("press0_early_state", {31'd0, state_a[0]}, 32'd0);
        chk("press0_early_pulse", {31'd0, press_a[0]}, 32'd0);
        tick();
        chk("press0_state", {31'd0, state_a[0]}, 32'd1);
        chk("press0_pulse", {31'd0, press_a[0]}, 32'd1);
        tick();
        chk("press0_pulse_clear", {31'd0, press_a[0]}, 32'd0);
        chk("press0_state_hold", {31'd0, state_a[0]}, 32'd1);
        keys_a[0] = 1'b0;
        ticks(5);
        chk("rel0_early", {31'd0, release_a[0]}, 32'd0);
        tick();
        chk("rel0_pulse", {31'd0, release_a[0]}, 32'd1);
        chk("rel0_state", {31'd0, state_a[0]}, 32'd0);
        chk("rel0_no_long", long_cnt[0], 32'd0);
        tick();

        // bounce rejection on channel 1
        p0 = press_cnt[1];
        keys_a[1] = 1'b1; tick();
        keys_a[1] = 1'b0; tick();
        keys_a[1] = 1'b1; tick();
        keys_a[1] = 1'b0; tick();
        keys_a[1] = 1'b1;
        ticks(5);
        chk("bounce_no_press", press_cnt[1] - p0, 32'd0);
        chk("bounce_state_low", {31'd0, state_a[1]}, 32'd0);
        tick();
        chk("bounce_press", {31'd0, press_a[1]}, 32'd1);
        ticks(4);
        chk("bounce_one_pulse", press_cnt[1] - p0, 32'd1);
        keys_a[1] = 1'b0;
        ticks(6);
        chk("bounce_release", {31'd0, release_a[1]}, 32'd1);
        tick();

        // long press on channel 2
        l0 = long_cnt[2];
        keys_a[2] = 1'b1;
        ticks(6);
        chk("long_accept", {31'd0, state_a[2]}, 32'd1);
        ticks(9);
        chk("long_not_yet", {31'd0, long_a[2]}, 32'd0);
        tick();
        chk("long_pulse", {31'd0, long_a[2]}, 32'd1);
        chk("long_no_press", {31'd0, press_a[2]}, 32'd0);
        tick();
        chk("long_clear", {31'd0, long_a[2]}, 32'd0);
        ticks(9);
        chk("long_once", long_cnt[2] - l0, 32'd1);
        keys_a[2] = 1'b0;
        ticks(5);
        chk("long_rel_early", {31'd0, release_a[2]}, 32'd0);
        tick();
        chk("long_release", {31'd0, release_a[2]}, 32'd1);
        chk("long_rel_state", {31'd0, state_a[2]}, 32'd0);
        tick();

        // short hold on channel 2: no long press
        l0 = long_cnt[2];
        r0 = rel_cnt[2];
        keys_a[2] = 1'b1;
        ticks(6);
        chk("short_accept", {31'd0, state_a[2]}, 32'd1);
        ticks(2);
        keys_a[2] = 1'b0;
        ticks(10);
        chk("short_no_long", long_cnt[2] - l0, 32'd0);
        chk("short_release", rel_cnt[2] - r0, 32'd1);

        // glitch while pressed on channel 3
        r0 = rel_cnt[3];
        keys_a[3] = 1'b1;
        ticks(6);
        chk("glitch_accept", {31'd0, state_a[3]}, 32'd1);
        tick();
        keys_a[3] = 1'b0;
        ticks(3);
        keys_a[3] = 1'b1;
        ticks(5);
        chk("glitch_state", {31'd0, state_a[3]}, 32'd1);
        chk("glitch_no_release", rel_cnt[3] - r0, 32'd0);
        chk("glitch_long_early", {31'd0, long_a[3]}, 32'd0);
        tick();
        chk("glitch_long_kept", {31'd0, long_a[3]}, 32'd1);
        keys_a[3] = 1'b0;
        ticks(6);
        chk("glitch_release", {31'd0, release_a[3]}, 32'd1);
        tick();

        // reset with channel 0 mid-window
        keys_a[0] = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_state", {28'd0, state_a}, 32'd0);
        chk("rst_mid_pulses", {20'd0, press_a, release_a, long_a}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_after_pulse", {31'd0, press_a[0]}, 32'd0);
        ticks(4);
        chk("rst_press_early", {31'd0, press_a[0]}, 32'd0);
        tick();
        chk("rst_press", {31'd0, press_a[0]}, 32'd1);
        chk("rst_press_state", {31'd0, state_a[0]}, 32'd1);
        keys_a[0] = 1'b0;
        ticks(7);

        // active-low instance, all channels together
        keys_b = 4'h0;
        ticks(5);
        chk("al_early", {24'd0, state_b, press_b}, 32'd0);
        tick();
        chk("al_press_all", {28'd0, press_b}, 32'hF);
        chk("al_state_all", {28'd0, state_b}, 32'hF);
        chk("al_no_rel_long", {24'd0, release_b, long_b}, 32'd0);
        tick();
        chk("al_press_clear", {28'd0, press_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel key debouncer for the 1 kHz key-scan domain. It replaces single-key, fixed-20 ms filtering with N independent channels. Each channel has its own input synchroniser, a programmable stability window, press and release event pulses, and long-press detection. It sits between the raw board push-buttons and the control FSMs, which consume clean levels and single-cycle events.

## Interface
- `N_KEYS`, default 4: number of independent key channels (≥1).
- `DEBOUNCE_CYCLES`, default 20: consecutive identical samples required to accept a new level (≥2; 20 = 20 ms at 1 kHz).
- `LONG_CYCLES`, default 1000: cycles a key must stay in the accepted-pressed state before `key_long` fires (≥2).
- `ACTIVE_LOW`, default 0: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".

Ports (all outputs registered):
- `clk_1KHz`, input, 1: the only clock; all logic on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `keys_in`, input, `N_KEYS`: raw asynchronous key inputs.
- `key_state`, output, `N_KEYS`: debounced level per channel; 1 = pressed, independent of `ACTIVE_LOW`.
- `key_press`, output, `N_KEYS`: 1-cycle pulse when a channel's `key_state` goes 0→1.
- `key_release`, output, `N_KEYS`: 1-cycle pulse when a channel's `key_state` goes 1→0.
- `key_long`, output, `N_KEYS`: 1-cycle pulse, once per press, when a held key reaches `LONG_CYCLES`.

## Operation
- Each channel is identical and independent, built with a generate loop. Channels share no state.
- Normalisation: `p = keys_in[i] ^ ACTIVE_LOW`, giving 1 = pressed.
- Synchroniser: two flops, `s1 <= p` and `s2 <= s1`. Only `s2` is used downstream.
- Debounce counter `dcnt`:
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == key_state`: `dcnt <= 0`.
  - Else, if `dcnt == DEBOUNCE_CYCLES-1`: `key_state <= s2`, `dcnt <= 0`, and the matching event pulse fires.
  - Else: `dcnt <= dcnt + 1`.
  - Any sample equal to `key_state` restarts the window. A glitch shorter than `DEBOUNCE_CYCLES` samples never changes `key_state`.
- Event pulses are registered in the same edge that updates `key_state`:
  - `key_press = 1` when the new state is 1.
  - `key_release = 1` when the new state is 0.
  - Both are cleared the next cycle unless re-triggered.
- Long-press counter `lcnt`:
  - Width is `$clog2(LONG_CYCLES+1)`.
  - Held at 0 while `key_state == 0`.
  - While `key_state == 1`, increments and saturates at `LONG_CYCLES`.
  - `key_long` pulses on the edge where `lcnt` goes from `LONG_CYCLES-1` to `LONG_CYCLES`. It fires exactly once per press.
  - Release clears `lcnt`. Release after a long press produces `key_release` normally.
- Per-channel states are RELEASED (`key_state`=0) and PRESSED (`key_state`=1), with an implicit PENDING phase whenever `dcnt != 0`.
  - RELEASED→PRESSED and PRESSED→RELEASED occur only through debounce-counter expiry.

## Timing
- Reset: when `rst_n == 0` at a rising edge, every channel clears to the following values.
  - `s1`, `s2`, `key_state`, `key_press`, `key_release`, `key_long`, `dcnt`, `lcnt` all go to 0.
  - `s1`, `s2` reset to 0, the released level after normalisation, so a key held through reset does not produce a spurious release.
  - A key held through reset is accepted as a fresh press `DEBOUNCE_CYCLES+2` cycles after reset deasserts.
- Press latency: raw input changes and is stable before edge e; `s2` reflects it after edge e+1; `key_state` and the pulse update at edge e+`DEBOUNCE_CYCLES`+1.
- Release latency: the same.
- Long-press timing: `key_long` asserts `LONG_CYCLES` edges after the edge that raised `key_state`.
- Reset mid-operation: pending counts and partial long-press counts are discarded. No pulse is emitted during or on the cycle after reset.
- A pulse that would coincide with a reset edge is suppressed.
- Simultaneous events across channels are independent. Any combination of bits may pulse in the same cycle.
- Within one channel:
  - `key_press` and `key_release` are never both 1.
  - `key_long` and `key_press` are never both 1, since `LONG_CYCLES` ≥ 2.
  - `key_long` may coincide with another channel's events.

## Test plan
Bench parameters: `N_KEYS`=4, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=0, unless noted.

1. Clean press: `keys_in[0]` goes 0→1 before edge 10 and stays there. `key_state[0]` is 1 and `key_press[0]` is 1 after edge 15 only; `key_press` is back to 0 after edge 16.
2. Bounce rejection: `keys_in[1]` toggles 1,0,1,0,1 on successive cycles, then holds 1. There is no `key_press[1]` until 4 consecutive 1-samples are seen at `s2`, and exactly one pulse occurs.
3. Long press and release: channel 2 is held for 20 cycles after acceptance.
   - `key_long[2]` pulses once, 10 edges after `key_state[2]` rises.
   - On release, `key_release[2]` fires 5 edges after the raw falling edge.
   - Holding for only 8 cycles produces no `key_long`.
4. Glitch in pressed state: with `key_state[3]`=1, `keys_in[3]` drops to 0 for 3 cycles. `key_state[3]` stays 1, with no release pulse and no `lcnt` reset.
5. Reset mid-count:
   - With `dcnt` at 2 on channel 0, assert `rst_n`=0 for one edge. All outputs read 0 afterwards.
   - With the key still held, `key_press[0]` occurs 6 edges after reset deasserts.
6. `ACTIVE_LOW`=1, all channels driven simultaneously: all 4 `keys_in` bits go 1→0 together. All 4 `key_press` bits pulse on the same cycle and `key_state` becomes 4'b1111.
